// File: rtl/jerky_counter_checker_pkg.sv
// jerky_counter_checker_pkg
//   Shared definitions for the jerky counter family: checker FSM state
//   encoding and the sequence arithmetic (next value, linear position).
//   The functions work on up to 32-bit values; callers truncate the result
//   to their own counter width.
package jerky_counter_checker_pkg;

   typedef enum logic [1:0] {
      ST_SEARCH  = 2'd0,
      ST_ACQUIRE = 2'd1,
      ST_LOCKED  = 2'd2
   } state_e;

   // Successor in the jerky sequence: evens ascending, then odds ascending.
   function automatic logic [31:0] jerky_next(input logic [31:0] v,
                                              input int unsigned size);
      logic [31:0] p;
      logic [31:0] r;
      p = 32'd1 << size;
      if (v[0] == 1'b0) begin
         r = (v == p - 32'd2) ? 32'd1 : v + 32'd2;
      end else begin
         r = (v == p - 32'd1) ? 32'd0 : v + 32'd2;
      end
      return r & (p - 32'd1);
   endfunction

   // Position of a value within the jerky sequence.
   function automatic logic [31:0] jerky_index(input logic [31:0] v,
                                               input int unsigned size);
      logic [31:0] p;
      logic [31:0] r;
      p = 32'd1 << size;
      if (v[0] == 1'b0) begin
         r = v >> 1;
      end else begin
         r = (p >> 1) + (v >> 1);
      end
      return r & (p - 32'd1);
   endfunction

endpackage

// File: rtl/jerky_counter_checker_decode.sv
// jerky_seq_decode
//   Combinational sequence arithmetic for one sampled value.
//   Ports:
//     value_i  sampled counter value
//     next_o   value that must follow value_i in the jerky sequence
//     index_o  linear position of value_i in the sequence
module jerky_seq_decode
   import jerky_counter_checker_pkg::*;
#(
   parameter int counter_size = 5
) (
   input  logic [counter_size-1:0] value_i,
   output logic [counter_size-1:0] next_o,
   output logic [counter_size-1:0] index_o
);

   assign next_o  = counter_size'(jerky_next(32'(value_i), counter_size));
   assign index_o = counter_size'(jerky_index(32'(value_i), counter_size));

endmodule

// File: rtl/jerky_counter_checker.sv
// jerky_counter_checker
//   Receive-side monitor for a jerky counter stream. Samples count_in on
//   enabled cycles, decodes its sequence position, acquires and holds lock,
//   and flags and counts sequence breaks while locked.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   SEARCH   | no reference yet; first enabled sample seeds expected value
//   ACQUIRE  | counting consecutive correct transitions toward lock
//   LOCKED   | stream tracked; a mismatch raises error and drops to ACQUIRE
//
//   Ports:
//     clk, reset    rising-edge clock, synchronous active-high reset
//     enable        sample qualifier
//     count_in      value from the jerky counter
//     linear_index  decoded position of the last sampled value
//     locked        high while LOCKED
//     error         one-cycle pulse on a mismatch in LOCKED
//     wrap          one-cycle pulse on a matching P-1 sample in LOCKED
//     error_count   saturating error count since reset
module jerky_counter_checker
   import jerky_counter_checker_pkg::*;
#(
   parameter int counter_size  = 5,
   parameter int lock_thresh   = 3,
   parameter int err_cnt_width = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic [counter_size-1:0]  count_in,
   output logic [counter_size-1:0]  linear_index,
   output logic                     locked,
   output logic                     error,
   output logic                     wrap,
   output logic [err_cnt_width-1:0] error_count
);

   localparam logic [counter_size-1:0] LAST_VAL = '1;
   localparam logic [3:0]              THRESH   = 4'(lock_thresh);

   state_e                    state_q, state_d;
   logic [counter_size-1:0]   exp_q, exp_d;
   logic [3:0]                match_q, match_d;
   logic [counter_size-1:0]   idx_q, idx_d;
   logic                      locked_q, locked_d;
   logic                      error_q, error_d;
   logic                      wrap_q, wrap_d;
   logic [err_cnt_width-1:0]  err_cnt_q, err_cnt_d;

   logic [counter_size-1:0]   seq_next;
   logic [counter_size-1:0]   seq_index;
   logic                      hit;

   jerky_seq_decode #(
      .counter_size(counter_size)
   ) u_decode (
      .value_i (count_in),
      .next_o  (seq_next),
      .index_o (seq_index)
   );

   assign hit = (count_in == exp_q);

   always_comb begin
      state_d   = state_q;
      exp_d     = exp_q;
      match_d   = match_q;
      idx_d     = idx_q;
      err_cnt_d = err_cnt_q;
      error_d   = 1'b0;
      wrap_d    = 1'b0;

      if (enable) begin
         idx_d = seq_index;
         // Every enabled sample, matched or not, re-seeds the expectation.
         exp_d = seq_next;
         case (state_q)
            ST_SEARCH: begin
               state_d = ST_ACQUIRE;
               match_d = 4'd0;
            end
            ST_ACQUIRE: begin
               if (hit) begin
                  match_d = match_q + 4'd1;
                  if (match_q + 4'd1 == THRESH) begin
                     state_d = ST_LOCKED;
                  end
               end else begin
                  match_d = 4'd0;
               end
            end
            ST_LOCKED: begin
               if (hit) begin
                  wrap_d = (count_in == LAST_VAL);
               end else begin
                  error_d = 1'b1;
                  if (err_cnt_q != '1) begin
                     err_cnt_d = err_cnt_q + err_cnt_width'(1);
                  end
                  state_d = ST_ACQUIRE;
                  match_d = 4'd0;
               end
            end
            default: begin
               state_d = ST_SEARCH;
               match_d = 4'd0;
            end
         endcase
      end

      locked_d = (state_d == ST_LOCKED);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_SEARCH;
         exp_q     <= '0;
         match_q   <= 4'd0;
         idx_q     <= '0;
         locked_q  <= 1'b0;
         error_q   <= 1'b0;
         wrap_q    <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         exp_q     <= exp_d;
         match_q   <= match_d;
         idx_q     <= idx_d;
         locked_q  <= locked_d;
         error_q   <= error_d;
         wrap_q    <= wrap_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign linear_index = idx_q;
   assign locked       = locked_q;
   assign error        = error_q;
   assign wrap         = wrap_q;
   assign error_count  = err_cnt_q;

endmodule

// File: tb/tb_jerky_counter_checker.sv
module tb_jerky_counter_checker;

   logic       clk;
   logic       reset;
   logic       enable;
   logic [4:0] count_in;
   logic [4:0] linear_index;
   logic       locked;
   logic       error;
   logic       wrap;
   logic [7:0] error_count;

   int n_cmp;
   int n_bad;
   int last_val;

   jerky_counter_checker #(
      .counter_size (5),
      .lock_thresh  (3),
      .err_cnt_width(8)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .count_in     (count_in),
      .linear_index (linear_index),
      .locked       (locked),
      .error        (error),
      .wrap         (wrap),
      .error_count  (error_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Successor via position table, independent of the RTL formulation.
   function automatic int bnext(input int v);
      int i;
      i = (v % 2 == 0) ? v / 2 : 16 + v / 2;
      i = (i + 1) % 32;
      return (i < 16) ? 2 * i : 2 * (i - 16) + 1;
   endfunction

   task automatic drive(input logic en, input int v);
      @(negedge clk);
      reset    = 1'b0;
      enable   = en;
      count_in = 5'(v);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         reset    = 1'b1;
         enable   = 1'b1;
         count_in = 5'd7;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      do_reset(3);
      n_cmp++;
      if ({linear_index, locked, error, wrap, error_count} !== 16'd0) begin
         n_bad++;
         $display("FAIL reset_outputs: got li=%0d lk=%0b err=%0b wr=%0b cnt=%0d, want all zero",
                  linear_index, locked, error, wrap, error_count);
      end
   endtask

   task automatic test_lock();
      int v;
      v = 0;
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, v);
         n_cmp++;
         if (locked !== 1'b0 || error !== 1'b0) begin
            n_bad++;
            $display("FAIL lock_early v=%0d: lk=%0b err=%0b, want 0 0", v, locked, error);
         end
         v = v + 2;
      end
      drive(1'b1, 6);
      n_cmp++;
      if (locked !== 1'b1 || error !== 1'b0 || linear_index !== 5'd3) begin
         n_bad++;
         $display("FAIL lock_after6: lk=%0b err=%0b li=%0d, want 1 0 3", locked, error, linear_index);
      end
      last_val = 6;
   endtask

   task automatic test_wrap();
      int wraps;
      wraps = 0;
      for (int v = 8; v <= 26; v += 2) drive(1'b1, v);
      drive(1'b1, 28);
      n_cmp++;
      if (linear_index !== 5'd14) begin
         n_bad++; $display("FAIL idx28: got %0d want 14", linear_index);
      end
      drive(1'b1, 30);
      n_cmp++;
      if (linear_index !== 5'd15) begin
         n_bad++; $display("FAIL idx30: got %0d want 15", linear_index);
      end
      drive(1'b1, 1);
      n_cmp++;
      if (linear_index !== 5'd16 || error !== 1'b0) begin
         n_bad++; $display("FAIL idx1: got li=%0d err=%0b want 16 0", linear_index, error);
      end
      drive(1'b1, 3);
      n_cmp++;
      if (linear_index !== 5'd17 || locked !== 1'b1) begin
         n_bad++; $display("FAIL idx3: got li=%0d lk=%0b want 17 1", linear_index, locked);
      end
      for (int v = 5; v <= 27; v += 2) begin
         drive(1'b1, v);
         if (wrap === 1'b1) wraps++;
      end
      drive(1'b1, 29);
      n_cmp++;
      if (wrap !== 1'b0 || linear_index !== 5'd30) begin
         n_bad++; $display("FAIL at29: wr=%0b li=%0d want 0 30", wrap, linear_index);
      end
      drive(1'b1, 31);
      n_cmp++;
      if (wrap !== 1'b1 || linear_index !== 5'd31) begin
         n_bad++; $display("FAIL wrap31: wr=%0b li=%0d want 1 31", wrap, linear_index);
      end
      wraps++;
      drive(1'b0, 12);
      n_cmp++;
      if (wrap !== 1'b0 || linear_index !== 5'd31) begin
         n_bad++; $display("FAIL wrap_gap: wr=%0b li=%0d want 0 31", wrap, linear_index);
      end
      drive(1'b1, 0);
      n_cmp++;
      if (wrap !== 1'b0 || linear_index !== 5'd0 || error !== 1'b0 || locked !== 1'b1) begin
         n_bad++;
         $display("FAIL after0: wr=%0b li=%0d err=%0b lk=%0b want 0 0 0 1",
                  wrap, linear_index, error, locked);
      end
      n_cmp++;
      if (wraps !== 1) begin
         n_bad++; $display("FAIL wrap_count: got %0d pulses want 1", wraps);
      end
      last_val = 0;
   endtask

   task automatic test_error();
      for (int v = 2; v <= 8; v += 2) drive(1'b1, v);
      drive(1'b1, 14);
      n_cmp++;
      if (error !== 1'b1 || error_count !== 8'd1 || locked !== 1'b0 || linear_index !== 5'd7) begin
         n_bad++;
         $display("FAIL mismatch14: err=%0b cnt=%0d lk=%0b li=%0d want 1 1 0 7",
                  error, error_count, locked, linear_index);
      end
      drive(1'b1, 16);
      n_cmp++;
      if (error !== 1'b0 || locked !== 1'b0) begin
         n_bad++; $display("FAIL err_pulse16: err=%0b lk=%0b want 0 0", error, locked);
      end
      drive(1'b1, 18);
      n_cmp++;
      if (locked !== 1'b0) begin
         n_bad++; $display("FAIL relock18: lk=%0b want 0", locked);
      end
      drive(1'b1, 20);
      n_cmp++;
      if (locked !== 1'b1 || error_count !== 8'd1 || linear_index !== 5'd10) begin
         n_bad++;
         $display("FAIL relock20: lk=%0b cnt=%0d li=%0d want 1 1 10", locked, error_count, linear_index);
      end
      last_val = 20;
   endtask

   task automatic test_gap();
      for (int k = 0; k < 5; k++) begin
         drive(1'b0, int'($urandom_range(31, 0)));
         n_cmp++;
         if (locked !== 1'b1 || error !== 1'b0 || wrap !== 1'b0 || linear_index !== 5'd10
             || error_count !== 8'd1) begin
            n_bad++;
            $display("FAIL gap_hold%0d: lk=%0b err=%0b wr=%0b li=%0d cnt=%0d want 1 0 0 10 1",
                     k, locked, error, wrap, linear_index, error_count);
         end
      end
      drive(1'b1, 22);
      n_cmp++;
      if (locked !== 1'b1 || error !== 1'b0 || linear_index !== 5'd11) begin
         n_bad++;
         $display("FAIL gap_resume: lk=%0b err=%0b li=%0d want 1 0 11", locked, error, linear_index);
      end
      last_val = 22;
   endtask

   // Each round: stall (repeat last value) while locked, then three correct
   // transitions to relock.
   task automatic error_rounds(input int rounds, input int start_cnt);
      int model_cnt;
      model_cnt = start_cnt;
      for (int r = 0; r < rounds; r++) begin
         drive(1'b1, last_val);
         if (model_cnt < 255) model_cnt++;
         n_cmp++;
         if (error !== 1'b1 || error_count !== 8'(model_cnt)) begin
            n_bad++;
            $display("FAIL stall_err r=%0d: err=%0b cnt=%0d want 1 %0d", r, error, error_count, model_cnt);
         end
         for (int k = 0; k < 3; k++) begin
            last_val = bnext(last_val);
            drive(1'b1, last_val);
         end
         n_cmp++;
         if (locked !== 1'b1) begin
            n_bad++; $display("FAIL relock r=%0d: lk=%0b want 1", r, locked);
         end
      end
   endtask

   task automatic test_saturate();
      error_rounds(300, 1);
      n_cmp++;
      if (error_count !== 8'd255) begin
         n_bad++; $display("FAIL saturate: cnt=%0d want 255", error_count);
      end
   endtask

   task automatic test_back_to_back();
      do_reset(1);
      for (int v = 0; v <= 6; v += 2) drive(1'b1, v);
      last_val = 6;
      error_rounds(4, 0);
      n_cmp++;
      if (locked !== 1'b1 || error_count !== 8'd4) begin
         n_bad++; $display("FAIL pre_reset: lk=%0b cnt=%0d want 1 4", locked, error_count);
      end
      do_reset(1);
      n_cmp++;
      if (locked !== 1'b0 || error_count !== 8'd0 || linear_index !== 5'd0 || error !== 1'b0) begin
         n_bad++;
         $display("FAIL midreset: lk=%0b cnt=%0d li=%0d err=%0b want 0 0 0 0",
                  locked, error_count, linear_index, error);
      end
      for (int v = 10; v <= 14; v += 2) begin
         drive(1'b1, v);
         n_cmp++;
         if (locked !== 1'b0) begin
            n_bad++; $display("FAIL fresh_run v=%0d: lk=%0b want 0", v, locked);
         end
      end
      drive(1'b1, 16);
      n_cmp++;
      if (locked !== 1'b1 || linear_index !== 5'd8 || error_count !== 8'd0) begin
         n_bad++;
         $display("FAIL fresh_lock: lk=%0b li=%0d cnt=%0d want 1 8 0", locked, linear_index, error_count);
      end
   endtask

   initial begin
      n_cmp    = 0;
      n_bad    = 0;
      last_val = 0;
      reset    = 1'b1;
      enable   = 1'b0;
      count_in = 5'd0;
      test_reset();
      test_lock();
      test_wrap();
      test_error();
      test_gap();
      test_saturate();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
